// File: rtl/utils_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package utils_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  localparam int unsigned DIV_WIDTH = 32;
  localparam logic [DIV_WIDTH-1:0] DIV0_QUOT = '1;
  localparam logic [DIV_WIDTH-1:0] OVF_QUOT  = 32'h8000_0000;

endpackage

// File: rtl/utils_div_step.sv
// One combinational restoring-division iteration on magnitudes.
module utils_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // Partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits
  assign w_shift = {i_rem, i_bit};
  assign w_diff  = w_shift - {1'b0, i_div};
  assign o_qbit  = ~w_diff[WIDTH];
  assign o_rem   = o_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/utils_divider_32.sv
// Sequential signed/unsigned integer divider, one quotient bit per cycle, valid/ready on both sides.
module utils_divider_32
  import utils_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] L_DIV0 = WIDTH'(DIV0_QUOT);
  localparam logic [WIDTH-1:0] L_OVF  = WIDTH'(OVF_QUOT);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic             r_qneg;
  logic             r_rneg;
  logic             r_dbz;

  logic             w_accept;
  logic             w_div0;
  logic             w_ovf;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic             w_qbit;

  assign w_div0    = (divisor == '0);
  assign w_ovf     = in_signed && (dividend == L_OVF) && (divisor == '1);
  assign w_dvd_mag = (in_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_dvs_mag = (in_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  utils_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_div  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          w_accept    = 1'b1;
          w_state_nxt = (w_div0 || w_ovf) ? DONE : CALC;
        end
      end
      CALC: if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = FIX;
      FIX:  w_state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_rem  <= '0;
      r_quot <= '0;
      r_qneg <= 1'b0;
      r_rneg <= 1'b0;
      r_dbz  <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
      r_dbz <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_cnt  <= '0;
          r_dbz  <= w_div0;
          r_qneg <= in_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_rneg <= in_signed & dividend[WIDTH-1];
          r_dvd  <= w_dvd_mag;
          r_dvs  <= w_dvs_mag;
          if (w_div0) begin
            r_quot <= L_DIV0;
            r_rem  <= dividend;
          end else if (w_ovf) begin
            r_quot <= L_OVF;
            r_rem  <= '0;
          end else begin
            r_quot <= '0;
            r_rem  <= '0;
          end
        end
        CALC: begin
          r_rem  <= w_rem_nxt;
          r_quot <= {r_quot[WIDTH-2:0], w_qbit};
          r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          if (r_qneg) r_quot <= -r_quot;
          if (r_rneg) r_rem  <= -r_rem;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_utils_divider_32.sv
// Scoreboard bench for utils_divider_32: latency, results, backpressure, flush and async reset.
module tb_utils_divider_32;

  localparam int W = 32;
  localparam int LAT_NORM = 34;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_signed = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready;
  logic         out_valid;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  utils_divider_32 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_signed   (in_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == '1) begin
      e.q = 32'h8000_0000; e.r = '0; e.dz = 1'b0;
    end else if (sgn) begin
      e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b); e.dz = 1'b0;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Present one request from a negedge; returns just after the accepting edge.
  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL issue_ready actual=%b required=1", in_ready);
    end
    in_valid = 1'b1; in_signed = sgn; dividend = a; divisor = b;
    if (push) sb.push_back(model(sgn, a, b));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat, input string nm);
    int lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s_latency actual=%0d required=%0d", nm, lat, exp_lat);
    end
  endtask

  task automatic check_pop(input string nm, output exp_t e);
    e = '0;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_scoreboard actual=empty required=entry", nm);
      return;
    end
    e = sb.pop_front();
    if ({out_valid, quotient, remainder, div_by_zero} !== {1'b1, e.q, e.r, e.dz}) begin
      bad++;
      $display("FAIL %s actual=v%b q=%h r=%h dz=%b required=v1 q=%h r=%h dz=%b",
               nm, out_valid, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic run_one(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input string nm);
    exp_t e;
    issue(sgn, a, b, 1'b1);
    wait_result(lat, nm);
    check_pop(nm, e);
    release_out();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      bad++;
      $display("FAIL reset actual=rdy%b v%b q=%h r=%h dz=%b required=rdy1 v0 q=0 r=0 dz=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    run_one(1'b0, 32'd100, 32'd7, LAT_NORM, "u_100_7");
    for (int i = 0; i < 3; i++)
      run_one(1'b0, $urandom, $urandom_range(1, 100000), LAT_NORM, "u_rand");
    run_one(1'b0, 32'hDEAD_BEEF, 32'hF000_0001, LAT_NORM, "u_big_div");
  endtask

  task automatic test_signed();
    logic [W-1:0] b;
    run_one(1'b1, 32'hFFFF_FF9C, 32'd7, LAT_NORM, "s_m100_7");
    run_one(1'b1, 32'd100, 32'hFFFF_FFF9, LAT_NORM, "s_100_m7");
    run_one(1'b1, 32'h8000_0000, 32'd2, LAT_NORM, "s_min_2");
    for (int i = 0; i < 3; i++) begin
      b = $urandom_range(1, 5000);
      if ($urandom_range(0, 1) == 1) b = -b;
      run_one(1'b1, $urandom, b, LAT_NORM, "s_rand");
    end
  endtask

  task automatic test_div0();
    run_one(1'b0, 32'h1234_5678, 32'd0, 1, "div0_u");
    run_one(1'b1, 32'h1234_5678, 32'd0, 1, "div0_s");
  endtask

  task automatic test_overflow();
    run_one(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, "ovf_s");
    run_one(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, LAT_NORM, "ovf_u");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    issue(1'b0, 32'd12345, 32'd10, 1'b1);
    wait_result(LAT_NORM, "bp");
    check_pop("bp", e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, e.q, e.r, e.dz}) begin
        bad++;
        $display("FAIL bp_hold actual=v%b rdy%b q=%h r=%h dz=%b required=v1 rdy0 q=%h r=%h dz=%b",
                 out_valid, in_ready, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
      end
    end
    release_out();
    @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release actual=rdy%b v%b required=rdy1 v0", in_ready, out_valid);
    end
    run_one(1'b0, 32'hFFFF_FFFF, 32'd1, LAT_NORM, "after_bp");
  endtask

  task automatic test_flush();
    int seen = 0;
    issue(1'b0, 32'd1000, 32'd3, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; dividend = 32'd55; divisor = 32'd5;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, div_by_zero} !== 3'b100) begin
      bad++;
      $display("FAIL flush_idle actual=rdy%b v%b dz%b required=rdy1 v0 dz0", in_ready, out_valid, div_by_zero);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL flush_no_output actual=%0d busy_cycles required=0", seen);
    end
    run_one(1'b0, 32'd55, 32'd5, LAT_NORM, "after_flush");
  endtask

  task automatic test_async_reset();
    int seen = 0;
    issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      bad++;
      $display("FAIL async_reset actual=rdy%b v%b q=%h r=%h dz=%b required=rdy1 v0 q=0 r=0 dz=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL async_reset_discard actual=%0d valid_cycles required=0", seen);
    end
    run_one(1'b1, 32'hFFFF_FF9C, 32'd7, LAT_NORM, "after_reset");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div0();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_async_reset();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
